// File: rtl/momentum_pkg.sv
// Shared widths, object index constants and small helpers for the
// momentum engine scheduler.
package momentum_pkg;
   localparam int DEF_N_OBJ = 4;
   localparam int DEF_X_W   = 11;
   localparam int DEF_Y_W   = 10;
   localparam int DEF_ST_W  = 4;

   // Upper bound on the number of multiplexed objects.
   localparam int MAX_OBJ = 16;

   // Fixed object slots.
   localparam int OBJ_PLAYER1 = 0;
   localparam int OBJ_PLAYER2 = 1;
   localparam int OBJ_CANNON  = 2;

   // Index of the highest set bit of a mask (0 when the mask is empty).
   function automatic logic [3:0] highest_set(input logic [MAX_OBJ-1:0] mask);
      highest_set = '0;
      for (int i = 0; i < MAX_OBJ; i++) begin
         if (mask[i]) highest_set = 4'(i);
      end
   endfunction
endpackage

// File: rtl/momentum_scheduler_rr_next_active.sv
// Wrap-around search for the next active object after the current pointer.
// When only the current object is active the search lands back on it.
module rr_next_active
   import momentum_pkg::*;
#(
   parameter int N = DEF_N_OBJ,
   parameter int W = $clog2(DEF_N_OBJ)
) (
   input  logic [N-1:0] mask,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] next,
   output logic         found
);

   // Scan offsets from farthest to nearest so the nearest active index wins.
   always_comb begin
      next  = ptr;
      found = 1'b0;
      for (int off = N; off >= 1; off--) begin
         if (mask[(int'(ptr) + off) % N]) begin
            next  = W'((int'(ptr) + off) % N);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/momentum_scheduler.sv
// Round-robin time-multiplexer in front of the shared momentum engine.
// Issues one active object per cycle, tags it, and routes the engine's
// result back to that object's state slot LAT cycles later.
module momentum_scheduler
   import momentum_pkg::*;
#(
   parameter int N_OBJ = DEF_N_OBJ,
   parameter int X_W   = DEF_X_W,
   parameter int Y_W   = DEF_Y_W,
   parameter int ST_W  = DEF_ST_W,
   parameter int LAT   = 2,
   parameter int ID_W  = $clog2(N_OBJ)
) (
   input  logic                  clk_slow,
   input  logic                  rst,
   input  logic [N_OBJ*X_W-1:0]  obj_x,
   input  logic [N_OBJ*Y_W-1:0]  obj_y,
   input  logic [N_OBJ-1:0]      obj_active,
   input  logic                  pause,
   output logic [X_W-1:0]        object_x,
   output logic [Y_W-1:0]        object_y,
   output logic                  object_valid,
   output logic [ID_W-1:0]       object_id,
   input  logic [ST_W-1:0]       object_state,
   output logic [N_OBJ*ST_W-1:0] obj_state,
   output logic [N_OBJ-1:0]      obj_state_valid,
   output logic                  frame_done
);

   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] next_idx;
   logic            found;
   logic [ID_W-1:0] top_idx;

   // Tag pipeline: stage LAT-1 lines up with the engine result.
   logic [LAT-1:0]  tag_valid;
   logic [ID_W-1:0] tag_id [LAT];
   logic            ret_valid;
   logic [ID_W-1:0] ret_id;

   rr_next_active #(
      .N(N_OBJ),
      .W(ID_W)
   ) u_search (
      .mask (obj_active),
      .ptr  (ptr),
      .next (next_idx),
      .found(found)
   );

   assign top_idx   = ID_W'(highest_set(MAX_OBJ'(obj_active)));
   assign ret_valid = tag_valid[LAT-1];
   assign ret_id    = tag_id[LAT-1];

   // Issue stage: present the next active object, or idle holding position.
   always_ff @(posedge clk_slow or posedge rst) begin
      if (rst) begin
         ptr          <= ID_W'(N_OBJ - 1);
         object_x     <= '0;
         object_y     <= '0;
         object_id    <= '0;
         object_valid <= 1'b0;
         frame_done   <= 1'b0;
      end else if (!pause && found) begin
         ptr          <= next_idx;
         object_x     <= obj_x[next_idx*X_W +: X_W];
         object_y     <= obj_y[next_idx*Y_W +: Y_W];
         object_id    <= next_idx;
         object_valid <= 1'b1;
         frame_done   <= (next_idx == top_idx);
      end else begin
         object_valid <= 1'b0;
         frame_done   <= 1'b0;
      end
   end

   // Shift {valid,id} down the tag pipeline every cycle.
   always_ff @(posedge clk_slow or posedge rst) begin
      if (rst) begin
         tag_valid <= '0;
         for (int i = 0; i < LAT; i++) tag_id[i] <= '0;
      end else begin
         tag_valid[0] <= object_valid;
         tag_id[0]    <= object_id;
         for (int i = 1; i < LAT; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_id[i]    <= tag_id[i-1];
         end
      end
   end

   // Return path: accept the result for still-active objects, drop otherwise.
   always_ff @(posedge clk_slow or posedge rst) begin
      if (rst) begin
         obj_state       <= '0;
         obj_state_valid <= '0;
      end else begin
         obj_state_valid <= '0;
         if (ret_valid && obj_active[ret_id]) begin
            obj_state[ret_id*ST_W +: ST_W] <= object_state;
            obj_state_valid[ret_id]        <= 1'b1;
         end
      end
   end

endmodule
